// File: rtl/mod_residue_encoder.sv
// Bit-serial restoring binary-to-residue converter: out_res = in_data mod in_mod, MSB first.
// Define MOD_RESIDUE_FAST_EN to retire two dividend bits per cycle (DATA_W must then be even).
module mod_residue_encoder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MOD_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [MOD_W-1:0]  in_mod_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [MOD_W-1:0]  out_res_o,
  output logic              out_err_o
);

`ifdef MOD_RESIDUE_FAST_EN
  localparam int unsigned Shift = 2;
`else
  localparam int unsigned Shift = 1;
`endif
  localparam int unsigned Steps = DATA_W / Shift;
  localparam int unsigned CntW  = $clog2(Steps + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   d_q;
  logic [MOD_W-1:0]    m_q;
  // R < M always holds, so the stored remainder never needs its extra bit; T is widened instead.
  logic [MOD_W-1:0]    r_q;
  logic [CntW-1:0]     cnt_q;
  logic                err_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [MOD_W-1:0]    out_res_q;
  logic                out_err_q;
  logic [MOD_W-1:0]    r_d;

  function automatic logic [MOD_W-1:0] restore_step(input logic [MOD_W-1:0] r,
                                                    input logic             b,
                                                    input logic [MOD_W-1:0] m);
    logic [MOD_W:0] t;
    t = {r, b};
    if (t >= {1'b0, m}) begin
      return MOD_W'(t - {1'b0, m});
    end
    return t[MOD_W-1:0];
  endfunction

  always_comb begin
`ifdef MOD_RESIDUE_FAST_EN
    r_d = restore_step(restore_step(r_q, d_q[DATA_W-1], m_q), d_q[DATA_W-2], m_q);
`else
    r_d = restore_step(r_q, d_q[DATA_W-1], m_q);
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      d_q         <= '0;
      m_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            d_q        <= in_data_i;
            m_q        <= in_mod_i;
            r_q        <= '0;
            cnt_q      <= '0;
            err_q      <= (in_mod_i == '0);
            in_ready_q <= 1'b0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          // A zero modulus spends exactly one cycle here, giving a one-cycle error latency.
          if (err_q) begin
            out_res_q   <= '0;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            r_q   <= r_d;
            d_q   <= d_q << Shift;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntW'(Steps - 1)) begin
              out_res_q   <= r_d;
              out_err_q   <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end
          end
        end
        StDone: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_res_o   = out_res_q;
  assign out_err_o   = out_err_q;

endmodule

// File: tb/tb_mod_residue_encoder.sv
// Self-checking bench for mod_residue_encoder: directed cases, mid-run reset, random sweep
// against an arithmetic (d % m) reference.
module tb_mod_residue_encoder;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned MOD_W  = 4;
`ifdef MOD_RESIDUE_FAST_EN
  localparam int Lat = DATA_W / 2;
`else
  localparam int Lat = DATA_W;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [MOD_W-1:0]  in_mod;
  logic              out_valid;
  logic              out_ready;
  logic [MOD_W-1:0]  out_res;
  logic              out_err;

  int n_checks = 0;
  int n_err    = 0;

  mod_residue_encoder #(
    .DATA_W(DATA_W),
    .MOD_W (MOD_W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_mod_i   (in_mod),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_res_o  (out_res),
    .out_err_o  (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_res"}, 32'(out_res), 0);
    chk({tag, "_out_err"}, 32'(out_err), 0);
  endtask

  // Full transaction: accept, measure latency, compare to d % m, stall `hold` cycles, handshake.
  task automatic op(input logic [DATA_W-1:0] d, input logic [MOD_W-1:0] m, input int hold);
    int               cyc;
    logic [MOD_W-1:0] exp_res;
    logic             exp_err;
    logic [MOD_W-1:0] res_seen;
    logic             err_seen;
    exp_err = (m == 0);
    exp_res = exp_err ? '0 : MOD_W'(d % DATA_W'(m));

    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("in_ready_idle", 32'(in_ready), 1);

    in_valid = 1'b1;
    in_data  = d;
    in_mod   = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = DATA_W'($urandom);
    in_mod   = MOD_W'($urandom);
    chk("in_ready_busy", 32'(in_ready), 0);

    cyc = 0;
    while (!out_valid && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), exp_err ? 1 : Lat);
    chk("out_valid", 32'(out_valid), 1);
    chk("out_res", 32'(out_res), 32'(exp_res));
    chk("out_err", 32'(out_err), 32'(exp_err));
    if (!exp_err) chk("res_below_mod", 32'(out_res < m), 1);

    res_seen  = out_res;
    err_seen  = out_err;
    out_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_res", 32'(out_res), 32'(res_seen));
      chk("stall_err", 32'(out_err), 32'(err_seen));
      chk("stall_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_in_ready", 32'(in_ready), 1);
    chk("post_hs_out_valid", 32'(out_valid), 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mod    = '0;
    out_ready = 1'b0;
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    op(16'hFFFF, 4'd15, 0);
    op(16'd1000, 4'd7, 0);
    op(16'h1234, 4'd13, 0);
    op(16'hABCD, 4'd0, 0);
    op(16'hBEEF, 4'd1, 0);
    op(16'h8001, 4'd9, 5);
    op(16'h0000, 4'd5, 1);

    // Reset in the middle of RUN aborts the operation
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    in_mod   = 4'd15;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_run_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_result_after_abort", 32'(out_valid), 0);
    end
    op(16'h00FF, 4'd11, 0);

    // Random sweep, M in 1..15
    for (int i = 0; i < 40; i++) begin
      op(DATA_W'($urandom), MOD_W'($urandom_range(1, 15)), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
